// File: rtl/stream_xform_stage.sv
// Streaming transform stage: per-beat pass/add/xor, per-frame checksum and beat count,
// registered output with a one-entry skid buffer so in_ready can be a register.
module stream_xform_stage #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [AXI_DATA_WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [AXI_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  input  logic [1:0]                cfg_mode,
  input  logic [AXI_DATA_WIDTH-1:0] cfg_operand,
  input  logic                      sum_clear,
  output logic                      frame_done,
  output logic [AXI_DATA_WIDTH-1:0] frame_sum,
  output logic [CNT_WIDTH-1:0]      frame_beats
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_ADD   = 2'd1,
    MODE_XOR   = 2'd2,
    MODE_PASS3 = 2'd3
  } xform_mode_e;

  logic                      outValid_q, outValid_d;
  logic [AXI_DATA_WIDTH-1:0] outData_q, outData_d;
  logic                      outLast_q, outLast_d;
  logic                      skidValid_q, skidValid_d;
  logic [AXI_DATA_WIDTH-1:0] skidData_q, skidData_d;
  logic                      skidLast_q, skidLast_d;
  logic                      inReady_q, inReady_d;

  logic                      frameOpen_q, frameOpen_d;
  xform_mode_e               mode_q, mode_d;
  logic [AXI_DATA_WIDTH-1:0] operand_q, operand_d;
  logic [AXI_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic [AXI_DATA_WIDTH-1:0] frameSum_q, frameSum_d;
  logic [CNT_WIDTH-1:0]      frameBeats_q, frameBeats_d;

  logic                      accIn;
  logic                      emit;
  logic                      useLatched;
  xform_mode_e               effMode;
  logic [AXI_DATA_WIDTH-1:0] effOperand;
  logic [AXI_DATA_WIDTH-1:0] xformData;
  logic [AXI_DATA_WIDTH-1:0] accBase;
  logic [AXI_DATA_WIDTH-1:0] accSum;
  logic [CNT_WIDTH-1:0]      cntBase;
  logic [CNT_WIDTH-1:0]      cntInc;

  assign accIn = in_valid & inReady_q;
  assign emit  = outValid_q & out_ready;

  // A clear in the same cycle as a beat makes that beat the first of a new frame,
  // so it must see the live configuration rather than the old latch.
  assign useLatched = frameOpen_q & ~sum_clear;

  always_comb begin
    effMode    = useLatched ? mode_q : xform_mode_e'(cfg_mode);
    effOperand = useLatched ? operand_q : cfg_operand;
    case (effMode)
      MODE_ADD: xformData = in_data + effOperand;
      MODE_XOR: xformData = in_data ^ effOperand;
      default:  xformData = in_data;
    endcase
  end

  always_comb begin
    accBase      = sum_clear ? '0 : acc_q;
    cntBase      = sum_clear ? '0 : cnt_q;
    accSum       = accBase + xformData;
    cntInc       = cntBase + CNT_WIDTH'(1);
    acc_d        = accBase;
    cnt_d        = cntBase;
    frameOpen_d  = useLatched;
    mode_d       = sum_clear ? MODE_PASS : mode_q;
    operand_d    = sum_clear ? '0 : operand_q;
    done_d       = 1'b0;
    frameSum_d   = frameSum_q;
    frameBeats_d = frameBeats_q;
    if (accIn) begin
      if (in_last) begin
        acc_d        = '0;
        cnt_d        = '0;
        frameOpen_d  = 1'b0;
        mode_d       = MODE_PASS;
        operand_d    = '0;
        done_d       = 1'b1;
        frameSum_d   = accSum;
        frameBeats_d = cntInc;
      end else begin
        acc_d = accSum;
        cnt_d = cntInc;
        if (!useLatched) begin
          frameOpen_d = 1'b1;
          mode_d      = xform_mode_e'(cfg_mode);
          operand_d   = cfg_operand;
        end
      end
    end
  end

  // The skid entry always drains into the output register before new input is taken,
  // which keeps beat order and holds in_ready low only while the skid is occupied.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outLast_d   = outLast_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidLast_d  = skidLast_q;
    if (skidValid_q) begin
      if (emit) begin
        outData_d   = skidData_q;
        outLast_d   = skidLast_q;
        skidValid_d = 1'b0;
      end
    end else if (!outValid_q || emit) begin
      outValid_d = accIn;
      if (accIn) begin
        outData_d = xformData;
        outLast_d = in_last;
      end
    end else if (accIn) begin
      skidValid_d = 1'b1;
      skidData_d  = xformData;
      skidLast_d  = in_last;
    end
    inReady_d = ~skidValid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outLast_q    <= 1'b0;
      skidValid_q  <= 1'b0;
      skidData_q   <= '0;
      skidLast_q   <= 1'b0;
      inReady_q    <= 1'b1;
      frameOpen_q  <= 1'b0;
      mode_q       <= MODE_PASS;
      operand_q    <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      frameSum_q   <= '0;
      frameBeats_q <= '0;
    end else begin
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      outLast_q    <= outLast_d;
      skidValid_q  <= skidValid_d;
      skidData_q   <= skidData_d;
      skidLast_q   <= skidLast_d;
      inReady_q    <= inReady_d;
      frameOpen_q  <= frameOpen_d;
      mode_q       <= mode_d;
      operand_q    <= operand_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      frameSum_q   <= frameSum_d;
      frameBeats_q <= frameBeats_d;
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = outValid_q;
  assign out_data    = outData_q;
  assign out_last    = outLast_q;
  assign frame_done  = done_q;
  assign frame_sum   = frameSum_q;
  assign frame_beats = frameBeats_q;

endmodule

// File: tb/tb_stream_xform_stage.sv
// Scoreboard bench for stream_xform_stage: a reference model predicts each transformed
// beat and each completed frame; monitors compare them as the DUT produces them.
module tb_stream_xform_stage;

  localparam int W = 32;
  localparam int C = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic [1:0]   cfg_mode = 2'd0;
  logic [W-1:0] cfg_operand = '0;
  logic         sum_clear = 1'b0;
  logic         frame_done;
  logic [W-1:0] frame_sum;
  logic [C-1:0] frame_beats;

  stream_xform_stage #(.AXI_DATA_WIDTH(W), .CNT_WIDTH(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .cfg_mode(cfg_mode), .cfg_operand(cfg_operand), .sum_clear(sum_clear),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_beats(frame_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } beat_t;

  typedef struct {
    logic [W-1:0] sum;
    logic [C-1:0] beats;
  } frame_t;

  beat_t  expQ[$];
  frame_t frameQ[$];

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;
  int readyMode  = 0;
  bit monitorOn  = 1'b0;
  bit latCheck   = 1'b0;
  bit holdPending = 1'b0;
  logic [W:0] heldWord;

  logic         mActive;
  logic [1:0]   mMode;
  logic [W-1:0] mOp;
  logic [W-1:0] mAcc;
  logic [C-1:0] mCnt;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cycleCount);
  endtask

  function automatic logic [W-1:0] xform(input logic [W-1:0] d, input logic [1:0] m,
                                         input logic [W-1:0] op);
    case (m)
      2'd1:    return d + op;
      2'd2:    return d ^ op;
      default: return d;
    endcase
  endfunction

  task automatic modelReset();
    mActive = 1'b0; mMode = 2'd0; mOp = '0; mAcc = '0; mCnt = '0;
  endtask

  // Drives one beat and, once it is guaranteed to be taken at the next edge, predicts it.
  task automatic applyStimulus(input logic [W-1:0] d, input logic l, input logic [1:0] m,
                               input logic [W-1:0] op, input logic clr);
    int waited;
    logic [1:0]   em;
    logic [W-1:0] eop;
    logic [W-1:0] word;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    cfg_mode = m; cfg_operand = op; sum_clear = clr;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("inReadyTimeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (clr) begin
      mAcc = '0; mCnt = '0; mActive = 1'b0;
    end
    em   = mActive ? mMode : m;
    eop  = mActive ? mOp : op;
    word = xform(d, em, eop);
    mAcc = mAcc + word;
    mCnt = mCnt + 1'b1;
    if (l) begin
      frameQ.push_back('{sum: mAcc, beats: mCnt});
      mAcc = '0; mCnt = '0; mActive = 1'b0;
    end else if (!mActive) begin
      mActive = 1'b1; mMode = m; mOp = op;
    end
    expQ.push_back('{data: word, last: l, cyc: cycleCount});
  endtask

  task automatic goIdle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; sum_clear = 1'b0;
  endtask

  task automatic clearPulse();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; sum_clear = 1'b1;
    mAcc = '0; mCnt = '0; mActive = 1'b0;
  endtask

  task automatic drain();
    int waited;
    goIdle();
    readyMode = 0;
    waited = 0;
    while ((expQ.size() != 0 || frameQ.size() != 0) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drainBeats", 64'(expQ.size()), 64'd0);
    checkOutput("drainFrames", 64'(frameQ.size()), 64'd0);
    expQ.delete();
    frameQ.delete();
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) cycleCount++;

  // out_ready changes just after the active edge so the monitors see a settled value.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    beat_t  b;
    frame_t f;
    if (rst_n && monitorOn) begin
      if (!in_ready) checkOutput("inReadyLowNeedsOut", {63'd0, out_valid}, 64'd1);
      if (holdPending) begin
        checkOutput("holdValid", {63'd0, out_valid}, 64'd1);
        checkOutput("holdData", {31'd0, out_last, out_data}, {31'd0, heldWord});
        holdPending = 1'b0;
      end
      if (out_valid && !out_ready) begin
        holdPending = 1'b1;
        heldWord = {out_last, out_data};
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("outUnexpected", 64'd1, 64'd0);
        end else begin
          b = expQ.pop_front();
          checkOutput("outData", 64'(out_data), 64'(b.data));
          checkOutput("outLast", {63'd0, out_last}, {63'd0, b.last});
          if (latCheck) checkOutput("latency", 64'(cycleCount - b.cyc), 64'd1);
        end
      end
      if (frame_done) begin
        if (frameQ.size() == 0) begin
          checkOutput("frameUnexpected", 64'd1, 64'd0);
        end else begin
          f = frameQ.pop_front();
          checkOutput("frameSum", 64'(frame_sum), 64'(f.sum));
          checkOutput("frameBeats", 64'(frame_beats), 64'(f.beats));
        end
      end
    end
  end

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", {63'd0, in_ready}, 64'd1);
    checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("rstOutData", 64'(out_data), 64'd0);
    checkOutput("rstFrameDone", {63'd0, frame_done}, 64'd0);
    checkOutput("rstFrameSum", 64'(frame_sum), 64'd0);
    checkOutput("rstFrameBeats", 64'(frame_beats), 64'd0);
    rst_n = 1'b1;
    monitorOn = 1'b1;
    @(negedge clk);

    // Plain pass-through, back-to-back with one cycle of latency.
    $display("[TB] pass-through frame");
    latCheck = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(32'(i), i == 4, 2'd0, 32'h0, 1'b0);
    drain();

    $display("[TB] add with carry wrap");
    applyStimulus(32'h1, 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(32'h2, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0);
    drain();

    $display("[TB] mode change mid-frame");
    applyStimulus(32'h5, 1'b0, 2'd0, 32'h100, 1'b0);
    applyStimulus(32'h6, 1'b0, 2'd0, 32'h100, 1'b0);
    applyStimulus(32'h7, 1'b0, 2'd1, 32'h100, 1'b0);
    applyStimulus(32'h8, 1'b1, 2'd1, 32'h100, 1'b0);
    applyStimulus(32'h1, 1'b0, 2'd1, 32'h100, 1'b0);
    applyStimulus(32'h2, 1'b1, 2'd1, 32'h100, 1'b0);
    drain();

    $display("[TB] sum_clear cases");
    applyStimulus(32'h3, 1'b0, 2'd0, 32'h0, 1'b0);
    applyStimulus(32'h7, 1'b0, 2'd0, 32'h0, 1'b1);
    applyStimulus(32'h9, 1'b1, 2'd0, 32'h0, 1'b0);
    applyStimulus(32'h4, 1'b0, 2'd2, 32'hF0, 1'b0);
    applyStimulus(32'h2A, 1'b1, 2'd1, 32'h10, 1'b1);
    applyStimulus(32'h3, 1'b0, 2'd2, 32'hFF, 1'b0);
    clearPulse();
    applyStimulus(32'h9, 1'b1, 2'd1, 32'h1, 1'b0);
    drain();
    latCheck = 1'b0;

    $display("[TB] xor stream under toggling backpressure");
    readyMode = 1;
    for (int i = 0; i < 8; i++)
      applyStimulus(32'h1111_1111 * (i + 1), i == 7, 2'd2, 32'hA5A5_A5A5, 1'b0);
    drain();

    $display("[TB] random stream under random backpressure");
    readyMode = 3;
    for (int i = 0; i < 40; i++)
      applyStimulus($urandom, ($urandom_range(0, 4) == 0) || i == 39,
                    2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 9) == 0);
    drain();

    $display("[TB] reset with output and skid full");
    readyMode = 2;
    repeat (2) @(negedge clk);
    applyStimulus(32'hAAAA_0001, 1'b0, 2'd2, 32'h0F0F_0F0F, 1'b0);
    applyStimulus(32'hAAAA_0002, 1'b0, 2'd2, 32'h0F0F_0F0F, 1'b0);
    goIdle();
    checkOutput("skidFullInReady", {63'd0, in_ready}, 64'd0);
    checkOutput("skidFullOutValid", {63'd0, out_valid}, 64'd1);
    monitorOn = 1'b0;
    holdPending = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("midRstInReady", {63'd0, in_ready}, 64'd1);
    checkOutput("midRstFrameSum", 64'(frame_sum), 64'd0);
    checkOutput("midRstFrameBeats", 64'(frame_beats), 64'd0);
    expQ.delete();
    frameQ.delete();
    modelReset();
    readyMode = 0;
    rst_n = 1'b1;
    monitorOn = 1'b1;
    applyStimulus(32'h10, 1'b0, 2'd1, 32'h1, 1'b0);
    applyStimulus(32'h20, 1'b1, 2'd1, 32'h1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
